// File: rtl/pdp_io_pkg.sv
// Shared PDP-11 I/O constants: register addresses, Apple II card offsets,
// status bit positions and the bus INIT GP code.
package pdp_io_pkg;

    localparam logic [21:0] PPS_ADDR  = 22'o17777554;
    localparam logic [21:0] PPB_ADDR  = 22'o17777556;

    localparam logic [3:0]  A2PPS_OFF = 4'h6;
    localparam logic [3:0]  A2PPB_OFF = 4'h7;

    localparam int          PPS_ERR   = 15;
    localparam int          PPS_RDY   = 7;
    localparam int          PPS_IE    = 6;

    localparam logic [7:0]  GP_INIT   = 8'o014;

    // Assemble the PPS status word from its three live bits
    function automatic logic [15:0] pps_word(input logic err, input logic rdy, input logic ie);
        logic [15:0] w;
        w          = 16'h0000;
        w[PPS_ERR] = err;
        w[PPS_RDY] = rdy;
        w[PPS_IE]  = ie;
        return w;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with flush; a pop on empty is ignored, and a push on full
// is accepted only when a pop frees a slot in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem[rptr];

    // Storage array; contents are meaningless while the slot is not counted
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wptr] <= din;
    end

    // Pointers and occupancy; flush beats any simultaneous push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/pc11_punch.sv
// PC11 paper-tape punch channel: DCJ11 writes PPB into a FIFO, the Apple II
// drains it through A2PPS/A2PPB. Owns PPS (ERROR, READY, INT ENB) and irq.
module pc11_punch
    import pdp_io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_sel,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    input  logic        a2_wr,
    input  logic        a2_rd,
    input  logic [3:0]  a2_addr,
    input  logic [7:0]  a2_wdata,
    output logic [7:0]  a2_rdata,
    output logic        irq
);

    logic          ie;
    logic          err;
    logic          ready;
    logic          push;
    logic          pop;
    logic          flush;
    logic [7:0]    head;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic [4:0]    cnt5;
    logic [3:0]    cnt_sat;
    logic          a2_pps_wr;

    // Reads have no side effects on this side; only the low byte carries data
    wire unused = &{1'b0, cpu_rd, cpu_byte, cpu_wdata[15:8]};

    assign a2_pps_wr = a2_wr & (a2_addr == A2PPS_OFF);
    assign push      = cpu_wr & cpu_sel & ~init;
    assign pop       = a2_rd & (a2_addr == A2PPB_OFF) & ~init;
    assign flush     = init | (a2_pps_wr & a2_wdata[7]);
    assign ready     = ~full;

    byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (cpu_wdata[7:0]),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Host-visible count saturates at 15 so it fits the nibble field
    assign cnt5    = 5'(count);
    assign cnt_sat = (cnt5 > 5'd15) ? 4'hF : cnt5[3:0];

    // CPU read mux: PPB reads back as zero
    assign cpu_rdata = cpu_sel ? 16'h0000 : pps_word(err, ready, ie);

    // Apple II read mux: unknown offsets read as zero
    always_comb begin
        a2_rdata = 8'h00;
        case (a2_addr)
            A2PPS_OFF: a2_rdata = {~empty, err, 2'b00, cnt_sat};
            A2PPB_OFF: a2_rdata = head;
            default:   a2_rdata = 8'h00;
        endcase
    end

    // Control bits; INIT overrides any simultaneous access from either side
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie  <= 1'b0;
            err <= 1'b0;
            irq <= 1'b0;
        end else if (init) begin
            ie  <= 1'b0;
            err <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (cpu_wr && !cpu_sel) ie  <= cpu_wdata[PPS_IE];
            if (a2_pps_wr)          err <= a2_wdata[6];
            irq <= ie & (ready | err);
        end
    end

endmodule
